// File: rtl/regfile_access_ctrl.sv
// Synchronous initiator for the unclocked 32x32 register file: sequences
// setup/strobe/release on rf_write for writes and fills, and returns read pairs.
module regfile_access_ctrl #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int STROBE_CYCLES = 1,
    parameter int READ_SETTLE   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [5:0]        cmd_count,
    output logic              op_done,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_register_no,
    output logic [DATA_W-1:0] rf_reg_data,
    output logic [ADDR_W-1:0] rf_read_reg1,
    output logic [ADDR_W-1:0] rf_read_reg2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2
);

    // Handshakes: a command transfers on an edge with cmd_valid && cmd_ready;
    // a response transfers on an edge with rsp_valid && rsp_ready. Neither
    // valid depends combinationally on its ready.

    localparam int CNT_MAX = (STROBE_CYCLES > READ_SETTLE) ? STROBE_CYCLES : READ_SETTLE;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(READ_SETTLE - 1);
    localparam logic [5:0]       FILL_MAX    = 6'd32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        W_SETUP   = 3'd1,
        W_STROBE  = 3'd2,
        W_RELEASE = 3'd3,
        R_SETTLE  = 3'd4,
        R_RESP    = 3'd5,
        NOP_DONE  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [5:0]        remaining_q, remaining_d;
    logic              alive_q;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] rsel1_q, rsel1_d;
    logic [ADDR_W-1:0] rsel2_q, rsel2_d;
    logic [DATA_W-1:0] rsp1_q, rsp1_d;
    logic [DATA_W-1:0] rsp2_q, rsp2_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        remaining_d = remaining_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        rsel1_d     = rsel1_q;
        rsel2_d     = rsel2_q;
        rsp1_d      = rsp1_q;
        rsp2_d      = rsp2_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && alive_q) begin
                    case (cmd_op)
                        2'b00: begin
                            state_d     = W_SETUP;
                            waddr_d     = cmd_addr_a;
                            wdata_d     = cmd_data;
                            remaining_d = 6'd1;
                        end
                        2'b01: begin
                            // A zero-length fill completes like a nop.
                            if (cmd_count == 6'd0) begin
                                state_d = NOP_DONE;
                            end else begin
                                state_d     = W_SETUP;
                                waddr_d     = cmd_addr_a;
                                wdata_d     = cmd_data;
                                remaining_d = (cmd_count > FILL_MAX) ? FILL_MAX : cmd_count;
                            end
                        end
                        2'b10: begin
                            state_d = R_SETTLE;
                            rsel1_d = cmd_addr_a;
                            rsel2_d = cmd_addr_b;
                            cnt_d   = '0;
                        end
                        default: state_d = NOP_DONE;
                    endcase
                end
            end
            W_SETUP: begin
                state_d = W_STROBE;
                cnt_d   = '0;
            end
            W_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    state_d = W_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            W_RELEASE: begin
                // Address and data advance only after the strobe has fallen,
                // so the bus is held through the release cycle.
                if (remaining_q > 6'd1) begin
                    state_d     = W_SETUP;
                    remaining_d = remaining_q - 6'd1;
                    waddr_d     = waddr_q + ADDR_W'(1);
                    wdata_d     = wdata_q + DATA_W'(1);
                end else begin
                    state_d     = IDLE;
                    remaining_d = 6'd0;
                end
            end
            R_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = R_RESP;
                    rsp1_d  = rf_read_data1;
                    rsp2_d  = rf_read_data2;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            R_RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            NOP_DONE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            remaining_q <= 6'd0;
            alive_q     <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            rsel1_q     <= '0;
            rsel2_q     <= '0;
            rsp1_q      <= '0;
            rsp2_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            remaining_q <= remaining_d;
            alive_q     <= 1'b1;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            rsel1_q     <= rsel1_d;
            rsel2_q     <= rsel2_d;
            rsp1_q      <= rsp1_d;
            rsp2_q      <= rsp2_d;
        end
    end

    // alive_q keeps cmd_ready low while reset is held.
    assign cmd_ready      = alive_q && (state_q == IDLE);
    assign rf_write       = (state_q == W_STROBE);
    assign op_done        = ((state_q == W_RELEASE) && (remaining_q <= 6'd1)) ||
                            (state_q == NOP_DONE);
    assign rsp_valid      = (state_q == R_RESP);
    assign rsp_data1      = rsp1_q;
    assign rsp_data2      = rsp2_q;
    assign rf_register_no = waddr_q;
    assign rf_reg_data    = wdata_q;
    assign rf_read_reg1   = rsel1_q;
    assign rf_read_reg2   = rsel2_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl: a behavioural 32x32 register file
// plus a table of commands with hand-computed latencies, write counts and read data.
module tb_regfile_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b11;
    logic [4:0]  cmd_addr_a = '0;
    logic [4:0]  cmd_addr_b = '0;
    logic [31:0] cmd_data = '0;
    logic [5:0]  cmd_count = '0;
    logic        op_done;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data1, rsp_data2;
    logic        rf_write;
    logic [4:0]  rf_register_no, rf_read_reg1, rf_read_reg2;
    logic [31:0] rf_reg_data, rf_read_data1, rf_read_data2;

    logic [31:0] rf_mem [32] = '{default: 32'h0};

    int n_tests = 0;
    int n_fail  = 0;

    regfile_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_data(cmd_data),
        .cmd_count(cmd_count), .op_done(op_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
        .rf_write(rf_write), .rf_register_no(rf_register_no), .rf_reg_data(rf_reg_data),
        .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2)
    );

    always #5 clk = ~clk;

    // Register file: rising edge of the strobe captures, reads are combinational.
    always @(posedge rf_write) rf_mem[rf_register_no] <= rf_reg_data;
    assign rf_read_data1 = rf_mem[rf_read_reg1];
    assign rf_read_data2 = rf_mem[rf_read_reg2];

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [31:0] data;
        logic [5:0]  count;
        int          hold;
        int          exp_lat;
        int          exp_wr;
        logic [31:0] exp_d1;
        logic [31:0] exp_d2;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                                input logic [31:0] data, input logic [5:0] count, input int hold,
                                input int lat, input int wr, input logic [31:0] d1,
                                input logic [31:0] d2);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.data = data; v.count = count; v.hold = hold;
        v.exp_lat = lat; v.exp_wr = wr; v.exp_d1 = d1; v.exp_d2 = d2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          cyc, lat, nw, ndone, seq_err;
        logic        wr_prev;
        logic [4:0]  ea, la;
        logic [31:0] ed, ld, r1, r2;
        logic        stable;
        @(negedge clk);
        check($sformatf("v%0d_ready_before", idx), cmd_ready, 1);
        cmd_op = v.op; cmd_addr_a = v.a; cmd_addr_b = v.b;
        cmd_data = v.data; cmd_count = v.count; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'b11; cmd_addr_a = '0; cmd_addr_b = '0;
        cmd_data = '0; cmd_count = '0;
        ea = v.a; ed = v.data; la = '0; ld = '0;
        lat = 0; nw = 0; ndone = 0; seq_err = 0; wr_prev = 1'b0; cyc = 1;
        while (lat == 0 && cyc <= 200) begin
            if (rf_write && !wr_prev) begin
                if (rf_register_no !== ea || rf_reg_data !== ed) seq_err++;
                la = ea; ld = ed; ea = ea + 5'd1; ed = ed + 32'd1; nw++;
            end
            if (!rf_write && wr_prev) begin
                if (rf_register_no !== la || rf_reg_data !== ld) seq_err++;
            end
            wr_prev = rf_write;
            if (op_done) ndone++;
            if (op_done || rsp_valid) begin
                lat = cyc;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d_writes", idx), nw, v.exp_wr);
        check($sformatf("v%0d_write_bus", idx), seq_err, 0);
        if (lat == 0) return;
        if (v.op == 2'b10) begin
            r1 = rsp_data1; r2 = rsp_data2;
            check($sformatf("v%0d_rsp_data1", idx), r1, v.exp_d1);
            check($sformatf("v%0d_rsp_data2", idx), r2, v.exp_d2);
            stable = 1'b1;
            for (int h = 0; h < v.hold; h++) begin
                @(negedge clk);
                if (!rsp_valid || rsp_data1 !== r1 || rsp_data2 !== r2 || cmd_ready || rf_write)
                    stable = 1'b0;
            end
            if (v.hold > 0) check($sformatf("v%0d_rsp_held", idx), stable, 1);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check($sformatf("v%0d_rsp_valid_after", idx), rsp_valid, 0);
            check($sformatf("v%0d_ready_after", idx), cmd_ready, 1);
        end else begin
            check($sformatf("v%0d_done_count", idx), ndone, 1);
            @(negedge clk);
            check($sformatf("v%0d_done_single", idx), op_done, 0);
            check($sformatf("v%0d_ready_after", idx), cmd_ready, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, dones;

        vecs[0]  = mk(2'b00, 5'd5,  5'd0,  32'hDEADBEEF, 6'd0,  0, 3,  1,  32'h0, 32'h0);
        vecs[1]  = mk(2'b10, 5'd5,  5'd5,  32'h0,        6'd0,  0, 2,  0,  32'hDEADBEEF, 32'hDEADBEEF);
        vecs[2]  = mk(2'b01, 5'd0,  5'd0,  32'h0,        6'd31, 0, 93, 31, 32'h0, 32'h0);
        vecs[3]  = mk(2'b10, 5'd0,  5'd30, 32'h0,        6'd0,  0, 2,  0,  32'd0, 32'd30);
        vecs[4]  = mk(2'b01, 5'd30, 5'd0,  32'hFFFFFFFF, 6'd3,  0, 9,  3,  32'h0, 32'h0);
        vecs[5]  = mk(2'b10, 5'd30, 5'd31, 32'h0,        6'd0,  0, 2,  0,  32'hFFFFFFFF, 32'd0);
        vecs[6]  = mk(2'b10, 5'd0,  5'd1,  32'h0,        6'd0,  5, 2,  0,  32'd1, 32'd1);
        vecs[7]  = mk(2'b01, 5'd4,  5'd0,  32'd100,      6'd40, 0, 96, 32, 32'h0, 32'h0);
        vecs[8]  = mk(2'b10, 5'd3,  5'd4,  32'h0,        6'd0,  0, 2,  0,  32'd131, 32'd100);
        vecs[9]  = mk(2'b00, 5'd0,  5'd0,  32'h39CE7F9E, 6'd0,  0, 3,  1,  32'h0, 32'h0);
        vecs[10] = mk(2'b00, 5'd1,  5'd0,  32'hC0100420, 6'd0,  0, 3,  1,  32'h0, 32'h0);
        vecs[11] = mk(2'b10, 5'd0,  5'd1,  32'h0,        6'd0,  0, 2,  0,  32'h39CE7F9E, 32'hC0100420);
        vecs[12] = mk(2'b10, 5'd7,  5'd7,  32'h0,        6'd0,  0, 2,  0,  32'd103, 32'd103);
        vecs[13] = mk(2'b01, 5'd9,  5'd0,  32'd7,        6'd0,  0, 1,  0,  32'h0, 32'h0);
        vecs[14] = mk(2'b11, 5'd9,  5'd3,  32'h1234,     6'd5,  0, 1,  0,  32'h0, 32'h0);
        vecs[15] = mk(2'b10, 5'd9,  5'd2,  32'h0,        6'd0,  0, 2,  0,  32'd105, 32'd130);
        vecs[16] = mk(2'b10, 5'd10, 5'd11, 32'h0,        6'd0,  0, 2,  0,  32'h55, 32'd107);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 0);
        check("reset_rf_write", rf_write, 0);
        check("reset_op_done", op_done, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rf_register_no", rf_register_no, 0);
        check("reset_rf_reg_data", rf_reg_data, 0);
        check("reset_rf_read_reg1", rf_read_reg1, 0);
        check("reset_rsp_data1", rsp_data1, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release_ready", cmd_ready, 1);

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // Reset during the strobe of a fill
        @(negedge clk);
        cmd_op = 2'b01; cmd_addr_a = 5'd10; cmd_data = 32'h55; cmd_count = 6'd5; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        w = 0;
        while (!rf_write && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("abort_strobe_seen", rf_write, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_rf_write", rf_write, 0);
        check("abort_op_done", op_done, 0);
        check("abort_cmd_ready", cmd_ready, 0);
        check("abort_rf_register_no", rf_register_no, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready_after", cmd_ready, 1);
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            if (op_done || rf_write) dones++;
            @(negedge clk);
        end
        check("abort_quiet_after", dones, 0);

        // Reset while a read response is pending
        cmd_op = 2'b10; cmd_addr_a = 5'd4; cmd_addr_b = 5'd4; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        w = 0;
        while (!rsp_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("rsp_abort_seen", rsp_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rsp_abort_valid", rsp_valid, 0);
        check("rsp_abort_data1", rsp_data1, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rsp_abort_ready", cmd_ready, 1);
        check("rsp_abort_no_valid", rsp_valid, 0);

        run_vec(16, vecs[16]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
